// File: rtl/vga_fetch.sv
// vga_fetch: framebuffer prefetch stage ahead of the VGA timing generator.
// Fetches 16-bit pixel words over a single-outstanding req/ack bus into a
// small FIFO and presents the head word on pixel_data. The fetch address
// rewinds to BASE_ADDR on every frame restart (end_of_line && end_of_frame).
// Optional feature macro: VGA_FETCH_UNDERRUN_EN enables the sticky underrun
// flag; when it is undefined the flag is tied low.
module vga_fetch #(
    parameter int BASE_ADDR       = 0,
    parameter int ADDR_W          = 15,
    parameter int WORDS_PER_FRAME = 30050,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_data,
    input  logic              end_of_line,
    input  logic              end_of_frame,
    output logic [15:0]       pixel_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              underrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FC_W  = $clog2(WORDS_PER_FRAME + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [FC_W-1:0]   WPF_C   = FC_W'(WORDS_PER_FRAME);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    // Fetch FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;

    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;

    logic [ADDR_W-1:0] fetch_addr;
    logic [FC_W-1:0]   fetched;

    logic              restart;
    logic              push;
    logic              pop;
    logic              start_req;

    // Event decode: restart, FIFO push/pop and request launch for this cycle
    always_comb begin
        restart   = end_of_line && end_of_frame;
        // Data acked while in DRAIN, or coinciding with a restart, belongs
        // to the old frame and is dropped.
        push      = (state == ST_REQ) && mem_ack && !restart;
        // A pop on an empty FIFO moves nothing; restart swallows new_data.
        pop       = new_data && !restart && (count != '0);
        start_req = (state == ST_IDLE) && !restart &&
                    (count < DEPTH_C) && (fetched < WPF_C);
    end

    // Fetch FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_nxt = ST_IDLE;
                end else if (restart) begin
                    // The bus transaction cannot be abandoned, so wait it out.
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mem_ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state and bus request/address registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= BASE_C;
        end else begin
            state   <= state_nxt;
            // Request is high in REQ and DRAIN; every ack returns to IDLE,
            // which guarantees at least one low cycle between requests.
            mem_req <= (state_nxt != ST_IDLE);
            if (start_req) begin
                mem_addr <= fetch_addr;
            end
        end
    end

    // FIFO occupancy next value from the push/pop combination
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // FIFO pointers and occupancy, cleared by reset and frame restart
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (restart) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
        end
    end

    // FIFO storage; contents need no reset because count gates the output
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    // Fetch address and per-frame word counter, rewound on frame restart
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_addr <= BASE_C;
            fetched    <= '0;
        end else if (restart) begin
            fetch_addr <= BASE_C;
            fetched    <= '0;
        end else if (push) begin
            fetch_addr <= fetch_addr + ADDR_W'(1);
            if (fetched != WPF_C) begin
                fetched <= fetched + FC_W'(1);
            end
        end
    end

    assign pixel_data = (count == '0) ? 16'h0000 : fifo_mem[rd_ptr];

`ifdef VGA_FETCH_UNDERRUN_EN
    logic pop_empty;

    assign pop_empty = new_data && !restart && (count == '0);

    // Sticky underrun flag; only reset clears it, restart leaves it alone
    always_ff @(posedge clk) begin
        if (!reset) begin
            underrun <= 1'b0;
        end else if (pop_empty) begin
            underrun <= 1'b1;
        end
    end
`else
    assign underrun = 1'b0;
`endif

endmodule
